// File: rtl/static_bp_decode_pkg.sv
// Shared RISC-V decode constants for the static branch predictor front end.
package static_bp_decode_pkg;

    localparam logic [6:0]  OP_JAL           = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH        = 7'b1100011;
    localparam logic [6:0]  OP_JALR          = 7'b1100111;

    // Quadrant-1 compressed control-flow encodings
    localparam logic [1:0]  C_OP_CF          = 2'b01;
    localparam logic [2:0]  C_F3_JAL         = 3'b001;
    localparam logic [2:0]  C_F3_J           = 3'b101;
    localparam logic [2:0]  C_F3_BEQZ        = 3'b110;
    localparam logic [2:0]  C_F3_BNEZ        = 3'b111;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/static_bp_imm_gen.sv
// Combinational length detect, static taken/not-taken decision and
// sign-extended PC-relative offset for the word coming out of fetch.
module static_bp_imm_gen
    import static_bp_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_compress,
    output logic        pred_taken,
    output logic [31:0] offset
);

    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] cj_imm;
    logic [31:0] cb_imm;

    assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign cj_imm = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
    assign cb_imm = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10],
                     instr[4:3], 1'b0};

    always_comb begin
        is_compress = (instr[1:0] != 2'b11);
        pred_taken  = 1'b0;
        offset      = 32'd0;
        if (!is_compress) begin
            case (instr[6:0])
                OP_JAL: begin
                    pred_taken = 1'b1;
                    offset     = j_imm;
                end
                // Backward conditional branches are guessed taken (loop bias)
                OP_BRANCH: begin
                    pred_taken = instr[31];
                    offset     = b_imm;
                end
                OP_JALR: pred_taken = 1'b0;
                default: pred_taken = 1'b0;
            endcase
        end else if (instr[1:0] == C_OP_CF) begin
            case (instr[15:13])
                C_F3_J, C_F3_JAL: begin
                    pred_taken = 1'b1;
                    offset     = cj_imm;
                end
                C_F3_BEQZ, C_F3_BNEZ: begin
                    pred_taken = instr[12];
                    offset     = cb_imm;
                end
                default: pred_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/static_bp_decode.sv
// ID-front: tracks the PC of each fetched word, predicts statically, steers
// fetch with a redirect and registers the slot into the ID/EX register.
module static_bp_decode
    import static_bp_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned WARMUP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic [31:0] instruction_f_i,
    output logic [31:0] redirection_d_o,
    output logic        taken_d_o,
    output logic        is_compress_d_o,
    output logic [31:0] instruction_e_o,
    output logic [31:0] pc_e_o,
    output logic        pred_taken_e_o,
    output logic        valid_e_o
);

    logic [31:0] pc_reg;
    logic [1:0]  warm_cnt_reg;
    logic        shadow_reg;

    logic        pred_taken;
    logic [31:0] offset;
    logic [31:0] target;
    logic        cur_valid;
    logic        slot_taken;

    static_bp_imm_gen u_imm_gen (
        .instr       (instruction_f_i),
        .is_compress (is_compress_d_o),
        .pred_taken  (pred_taken),
        .offset      (offset)
    );

    assign target     = pc_reg + offset;
    assign cur_valid  = enable & ~flush_i & (warm_cnt_reg == 2'd0) & ~shadow_reg;
    assign slot_taken = cur_valid & pred_taken;

    // A later-stage flush always wins over our own prediction, even when stalled
    always_comb begin
        taken_d_o       = slot_taken;
        redirection_d_o = target;
        if (flush_i) begin
            taken_d_o       = 1'b1;
            redirection_d_o = flush_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            warm_cnt_reg    <= 2'(WARMUP);
            shadow_reg      <= 1'b0;
            instruction_e_o <= NOP;
            pc_e_o          <= 32'd0;
            pred_taken_e_o  <= 1'b0;
            valid_e_o       <= 1'b0;
        end else if (flush_i) begin
            pc_reg          <= flush_pc_i;
            shadow_reg      <= 1'b1;
            instruction_e_o <= NOP;
            pred_taken_e_o  <= 1'b0;
            valid_e_o       <= 1'b0;
        end else if (enable) begin
            if (warm_cnt_reg != 2'd0) begin
                warm_cnt_reg    <= warm_cnt_reg - 2'd1;
                instruction_e_o <= NOP;
                pred_taken_e_o  <= 1'b0;
                valid_e_o       <= 1'b0;
            end else if (shadow_reg) begin
                // Fetch still delivers one wrong-path word after any redirect
                shadow_reg      <= 1'b0;
                instruction_e_o <= NOP;
                pred_taken_e_o  <= 1'b0;
                valid_e_o       <= 1'b0;
            end else begin
                pc_reg          <= slot_taken ? target
                                 : pc_reg + (is_compress_d_o ? 32'd2 : 32'd4);
                shadow_reg      <= slot_taken;
                instruction_e_o <= instruction_f_i;
                pc_e_o          <= pc_reg;
                pred_taken_e_o  <= slot_taken;
                valid_e_o       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_static_bp_decode.sv
// Directed plus randomized check of static_bp_decode against a behavioural model.
module tb_static_bp_decode;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOPW   = 32'h0000_0013;
    localparam logic [31:0] BEQ_B  = 32'hFE00_0EE3;
    localparam logic [31:0] BNE_F  = 32'h0000_1463;
    localparam logic [31:0] JAL8   = 32'h0080_006F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'd0;
    logic [31:0] instruction_f_i = NOPW;
    logic [31:0] redirection_d_o;
    logic        taken_d_o;
    logic        is_compress_d_o;
    logic [31:0] instruction_e_o;
    logic [31:0] pc_e_o;
    logic        pred_taken_e_o;
    logic        valid_e_o;

    static_bp_decode dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .instruction_f_i (instruction_f_i),
        .redirection_d_o (redirection_d_o),
        .taken_d_o       (taken_d_o),
        .is_compress_d_o (is_compress_d_o),
        .instruction_e_o (instruction_e_o),
        .pc_e_o          (pc_e_o),
        .pred_taken_e_o  (pred_taken_e_o),
        .valid_e_o       (valid_e_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: PC of next word, slots still to ignore, and expected EX register
    logic [31:0] m_pc;
    int          m_warm;
    bit          m_squash;
    logic [31:0] m_ex_instr;
    logic [31:0] m_ex_pc;
    bit          m_ex_pred;
    bit          m_ex_valid;

    logic        s_taken;
    logic [31:0] s_redir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offsets rebuilt from the ISA field weights as plain signed arithmetic
    function automatic void ref_predict(input logic [31:0] w, output bit pred, output int off);
        pred = 0;
        off  = 0;
        if (w[1:0] == 2'b11) begin
            if (w[6:0] == 7'b1101111) begin
                pred = 1;
                off  = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                     - int'(w[31]) * (1 << 20);
            end else if (w[6:0] == 7'b1100011) begin
                pred = w[31];
                off  = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                     - int'(w[31]) * 4096;
            end
        end else if (w[1:0] == 2'b01) begin
            if (w[15:13] == 3'd1 || w[15:13] == 3'd5) begin
                pred = 1;
                off  = int'(w[5:3]) * 2 + int'(w[11]) * 16 + int'(w[2]) * 32 + int'(w[7]) * 64
                     + int'(w[6]) * 128 + int'(w[10:9]) * 256 + int'(w[8]) * 1024
                     - int'(w[12]) * 2048;
            end else if (w[15:13] == 3'd6 || w[15:13] == 3'd7) begin
                pred = w[12];
                off  = int'(w[4:3]) * 2 + int'(w[11:10]) * 8 + int'(w[2]) * 32
                     + int'(w[6:5]) * 64 - int'(w[12]) * 256;
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'b1101111;
            1: r[6:0] = 7'b1100011;
            2: r[6:0] = 7'b1100111;
            3: r[1:0] = 2'b01;
            4: r[1:0] = r[2] ? 2'b00 : 2'b10;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_ex();
        check("valid_e", valid_e_o, m_ex_valid);
        check("instr_e", instruction_e_o, m_ex_instr);
        check("pc_e", pc_e_o, m_ex_pc);
        check("pred_e", pred_taken_e_o, m_ex_pred);
    endtask

    task automatic do_reset(input bit fl);
        @(negedge clk);
        reset   = 1'b1;
        flush_i = fl;
        flush_pc_i = $urandom;
        enable  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        m_pc = RST_PC; m_warm = 2; m_squash = 0;
        m_ex_instr = NOPW; m_ex_pc = 32'd0; m_ex_pred = 0; m_ex_valid = 0;
        check_ex();
        $display("reset fl=%0b -> valid=%0b pc_e=%h", fl, valid_e_o, pc_e_o);
    endtask

    task automatic cycle(input logic [31:0] w, input bit en, input bit fl, input logic [31:0] fpc);
        bit          pred;
        int          off;
        bit          slot;
        bit          exp_taken;
        logic [31:0] target;
        @(negedge clk);
        reset = 1'b0; instruction_f_i = w; enable = en; flush_i = fl; flush_pc_i = fpc;
        #1;
        ref_predict(w, pred, off);
        slot      = en && !fl && m_warm == 0 && !m_squash;
        exp_taken = fl || (slot && pred);
        target    = fl ? fpc : m_pc + 32'(off);
        s_taken   = taken_d_o;
        s_redir   = redirection_d_o;
        check("taken_d", taken_d_o, exp_taken);
        check("is_compress", is_compress_d_o, w[1:0] != 2'b11);
        if (exp_taken) check("redirect", redirection_d_o, target);
        if (fl) begin
            m_pc = fpc; m_squash = 1;
            m_ex_valid = 0; m_ex_instr = NOPW; m_ex_pred = 0;
        end else if (en) begin
            if (m_warm > 0 || m_squash) begin
                if (m_warm > 0) m_warm--; else m_squash = 0;
                m_ex_valid = 0; m_ex_instr = NOPW; m_ex_pred = 0;
            end else begin
                m_ex_instr = w; m_ex_pc = m_pc; m_ex_pred = exp_taken; m_ex_valid = 1;
                m_pc     = exp_taken ? target : m_pc + ((w[1:0] != 2'b11) ? 32'd2 : 32'd4);
                m_squash = exp_taken;
            end
        end
        @(posedge clk);
        #1;
        check_ex();
        $display("w=%h en=%0b fl=%0b taken=%0b redir=%h | valid_e=%0b pc_e=%h pred_e=%0b",
                 w, en, fl, s_taken, s_redir, valid_e_o, pc_e_o, pred_taken_e_o);
    endtask

    initial begin
        do_reset(1'b0);
        // Warm-up then sequential PCs
        cycle(NOPW, 1, 0, 0);
        cycle(NOPW, 1, 0, 0);
        check("warm_valid", valid_e_o, 1'b0);
        cycle(NOPW, 1, 0, 0);
        check("first_pc", pc_e_o, RST_PC);
        cycle(NOPW, 1, 0, 0);
        check("second_pc", pc_e_o, 32'h8000_0004);
        // 16-bit then 32-bit length
        cycle(32'h0000_0001, 1, 0, 0);
        check("cnop_pc", pc_e_o, 32'h8000_0008);
        cycle(NOPW, 1, 0, 0);
        check("after_c_pc", pc_e_o, 32'h8000_000A);
        // Backward BEQ at 0x80000010
        cycle(NOPW, 1, 1, 32'h8000_0010);
        cycle(NOPW, 1, 0, 0);
        cycle(BEQ_B, 1, 0, 0);
        check("beq_taken", s_taken, 1'b1);
        check("beq_target", s_redir, 32'h8000_000C);
        check("beq_pred_e", pred_taken_e_o, 1'b1);
        cycle(NOPW, 1, 0, 0);
        check("beq_shadow", valid_e_o, 1'b0);
        cycle(BNE_F, 1, 0, 0);
        check("bne_taken", s_taken, 1'b0);
        check("bne_pc", pc_e_o, 32'h8000_000C);
        cycle(JAL8, 1, 0, 0);
        check("jal_target", s_redir, 32'h8000_0018);
        // Flush while stalled with a JAL on the input
        cycle(JAL8, 0, 1, 32'h8000_0100);
        check("flush_redir", s_redir, 32'h8000_0100);
        cycle(JAL8, 1, 0, 0);
        check("flush_squash", valid_e_o, 1'b0);
        cycle(NOPW, 1, 0, 0);
        check("flush_pc", pc_e_o, 32'h8000_0100);
        // Stall with a taken-looking word present
        for (int i = 0; i < 3; i++) begin
            cycle(JAL8, 0, 0, 0);
            check("stall_pc", pc_e_o, 32'h8000_0100);
        end
        // Reset while a shadow slot is pending
        cycle(JAL8, 1, 0, 0);
        do_reset(1'b1);
        cycle(NOPW, 1, 0, 0);
        cycle(NOPW, 1, 0, 0);
        cycle(NOPW, 1, 0, 0);
        check("rewarm_pc", pc_e_o, RST_PC);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                      $urandom & 32'hFFFF_FFFE);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/static_bp_decode.md
Name: static_bp_decode

Overview:
- ID-front block directly downstream of the fetch stage: consumes the fetch stage's instruction word every cycle.
- Tracks the architectural PC of that word, detects 16/32-bit length, and runs static branch prediction.
- Drives the redirect/length feedback the fetch stage uses to steer its fetch FIFO.
- Registers the valid instruction, its PC and its prediction into the ID/EX pipeline register.

Parameters:
- RESET_PC, 32'h80000000, PC of the first fetched instruction after reset.
- WARMUP, 2, cycles after reset release during which the fetch output is NOP filler and is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  pipeline advance; 0 = stall
- flush_i  in  1  redirect from a later stage (mispredict/trap)
- flush_pc_i  in  32  target PC for flush_i
- instruction_f_i  in  32  word from fetch; low 16 bits valid if compressed
- redirection_d_o  out  32  redirect target to fetch (combinational)
- taken_d_o  out  1  redirect strobe to fetch (combinational)
- is_compress_d_o  out  1  current word is 16-bit (combinational)
- instruction_e_o  out  32  registered instruction to EX
- pc_e_o  out  32  registered PC to EX
- pred_taken_e_o  out  1  registered prediction to EX
- valid_e_o  out  1  registered valid to EX

Behaviour:
- State: pc_q[31:0], warm_cnt[1:0], shadow_q, plus the ID/EX registers.
- Reset (sync): pc_q=RESET_PC, warm_cnt=WARMUP, shadow_q=0, instruction_e_o=32'h13, pc_e_o=0, pred_taken_e_o=0, valid_e_o=0.
- Slot valid: cur_valid = enable & ~flush_i & (warm_cnt==0) & ~shadow_q.
- Length: is_compress_d_o = (instruction_f_i[1:0] != 2'b11); computed unconditionally.
- 32-bit prediction:
  - JAL (opcode 7'b1101111): always taken, target = pc_q + sext(J-imm).
  - BRANCH (7'b1100011): taken iff imm[12] (instr[31]) = 1 (backward); target = pc_q + sext(B-imm).
  - JALR: never predicted.
- Compressed prediction (op=01):
  - C.J (funct3 101) and C.JAL (funct3 001): taken, target = pc_q + sext(CJ-imm).
  - C.BEQZ/C.BNEZ (110/111): taken iff offset sign (instr[12]) = 1; target = pc_q + sext(CB-imm).
  - C.JR/C.JALR: not predicted.
- Adds are mod 2^32; wrap-around is not flagged.
- Outputs, priority flush > prediction:
  - flush_i: taken_d_o=1, redirection_d_o=flush_pc_i (also when enable=0).
  - Otherwise: taken_d_o = cur_valid & pred; redirection_d_o = pred target (don't-care when taken_d_o=0).
- Sequential update, priority order:
  1. reset
  2. flush_i: pc_q=flush_pc_i, shadow_q=1, valid_e_o=0, instruction_e_o=32'h13.
  3. ~enable: hold all state, including warm_cnt and the ID/EX registers.
  4. warm_cnt!=0: decrement; valid_e_o=0; pc_q holds.
  5. shadow_q: clear shadow_q; valid_e_o=0; pc_q holds. This squashes the one stale word fetch delivers after a redirect.
  6. Normal: pc_q = taken ? target : pc_q + (is_compress ? 2 : 4); shadow_q = taken; ID/EX registers load {instruction_f_i, pc_q, taken, 1}.
- Invalid slots load instruction_e_o=32'h13 and pred_taken_e_o=0.
- Latency: feedback outputs are 0-cycle (same cycle as instruction_f_i); EX outputs are 1 cycle.
- Back-to-back taken: never possible, because shadow_q blocks the next slot.
- Reset asserted mid-stream overrides flush/shadow; warm-up restarts after release.

Decomposition:
- Shared package/include (rv_defs): opcode constants (OP_JAL, OP_BRANCH, OP_JALR), compressed funct3 codes, NOP=32'h13, RESET_PC default.
- One natural sub-module: static_bp_imm_gen (combinational). It takes the instruction and returns {is_compress, pred_taken, offset[31:0]}.
- The PC/shadow/warm-up FSM and the ID/EX registers stay in static_bp_decode.

Test Plan:
- Reset, release, enable=1, feed 32'h00000013 ×4: valid_e_o=0 for 2 cycles, then pc_e_o=80000000 then 80000004; taken_d_o never 1.
- After warm-up, feed 16'h0001 (C.NOP) then 32'h00000013: pc_e_o=80000000 then 80000002; is_compress_d_o=1 then 0.
- At pc 80000010, feed backward BEQ 32'hFE000EE3 (offset -4): taken_d_o=1, redirection_d_o=8000000C same cycle.
  - Next cycle: valid_e_o=1, pred_taken_e_o=1.
  - Following cycle: valid_e_o=0 (shadow), then the next word gets pc 8000000C.
- Forward BNE offset +8, then JAL 32'h0080006F: BNE gives taken_d_o=0 and pc+4; JAL gives taken_d_o=1, target = its pc+8.
- Raise flush_i with flush_pc_i=80000100 while enable=0 and a JAL is present:
  - taken_d_o=1, redirection_d_o=80000100.
  - Next slot squashed.
  - Following valid word has pc_e_o=80000100.
- Hold enable=0 for 3 cycles mid-stream: pc_q and EX outputs frozen, taken_d_o=0. Assert reset mid-shadow: all outputs reach reset values next cycle and warm-up repeats.
